// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: request record, FSM states and the
// address legality rule used against main_memory.
package lsu_pkg;

    localparam int MEM_WORDS_DEFAULT = 36;

    typedef struct packed {
        logic        is_store;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rd;
    } lsu_req_t;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } lsu_state_e;

    // A request may touch memory only if it is word aligned and inside the array.
    function automatic logic addr_is_legal(input logic [31:0] addr,
                                           input int unsigned mem_words);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < mem_words);
    endfunction

endpackage

// File: rtl/lsu_req_fifo.sv
// Request FIFO for the load/store unit. Uses extra-MSB pointers for full/empty
// detection. A push while full is dropped; there is no push-through.
module lsu_req_fifo
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  lsu_req_t push_req,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output lsu_req_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    lsu_req_t      mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; only the pointers define which
    // entries are valid, so resetting the array would add logic for no gain.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_req;
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/load_store_unit.sv
// Data-port initiator for main_memory: queues issue-slot load/store requests,
// issues them one at a time in program order and returns load results.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_WORDS  = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [4:0]  req_rd,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_en,
    output logic [31:0] mem_rd_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_data_out,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err_valid,
    output logic [31:0] err_addr,
    output logic        idle
);

    lsu_req_t   push_req;
    lsu_req_t   head;
    logic       full;
    logic       empty;
    logic       head_legal;

    lsu_state_e state_q, state_d;
    logic       pop;
    logic       issue_wr;
    logic       issue_rd;
    logic       issue_err;

    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic [31:0] rd_addr_q;
    logic [4:0]  rd_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic        err_valid_q;
    logic [31:0] err_addr_q;

    assign push_req = '{is_store: req_is_store, addr: req_addr,
                        data: req_data, rd: req_rd};

    lsu_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (req_valid),
        .push_req (push_req),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    assign head_legal = addr_is_legal(head.addr, MEM_WORDS);

    // NOTE: every output of this block is given a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        issue_wr  = 1'b0;
        issue_rd  = 1'b0;
        issue_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (!head_legal) begin
                        issue_err = 1'b1;
                    end else if (head.is_store) begin
                        issue_wr = 1'b1;
                    end else begin
                        issue_rd = 1'b1;
                        state_d  = LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: state_d = IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            rd_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (issue_wr) begin
                wr_addr_q <= head.addr;
                wr_data_q <= head.data;
            end
            if (issue_rd) begin
                rd_addr_q <= head.addr;
                rd_q      <= head.rd;
            end
            // Memory data is registered inside main_memory, so it is valid in LOAD_WAIT.
            wb_valid_q <= (state_q == LOAD_WAIT);
            if (state_q == LOAD_WAIT) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= mem_data_out;
            end
            err_valid_q <= issue_err;
            if (issue_err) begin
                err_addr_q <= head.addr;
            end
        end
    end

    // Strobes and addresses go out combinationally in the pop cycle; addresses hold afterwards.
    assign mem_wr_en   = issue_wr;
    assign mem_wr_addr = issue_wr ? head.addr : wr_addr_q;
    assign mem_wr_data = issue_wr ? head.data : wr_data_q;
    assign mem_rd_en   = issue_rd;
    assign mem_rd_addr = issue_rd ? head.addr : rd_addr_q;

    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;

    assign req_ready = !full;
    assign idle      = empty && (state_q == IDLE);

endmodule
